regfile_wb_queue: RTL and testbench

//  Writeback queue directly upstream of the MIPS regfile write port (WriteData/WriteRegister/RegWrite).

---
 rtl/regfile_wb_queue.sv | 111 +++++++++++
 tb/tb_regfile_wb_queue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the regfile write port, with read forwarding.
// Define WBQ_FORWARD_EN to build the pending-result forwarding compare logic.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          InValid,
  output logic          InReady,
  input  logic [4:0]    InReg,
  input  logic [31:0]   InData,
  input  logic          WbHold,
  output logic [4:0]    WriteRegister,
  output logic [31:0]   WriteData,
  output logic          RegWrite,
  input  logic [4:0]    ReadRegister1,
  input  logic [4:0]    ReadRegister2,
  output logic          Fwd1Hit,
  output logic [31:0]   Fwd1Data,
  output logic          Fwd2Hit,
  output logic [31:0]   Fwd2Data,
  output logic [AW:0]   Count
);

  logic [4:0]    r_reg  [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign InReady = !w_full;
  assign Count   = r_count;

  // Reset gates the write so a dropped entry never reaches the regfile.
  assign w_pop    = !Reset && !w_empty && !WbHold;
  assign RegWrite = w_pop;
  assign w_push   = InValid && !w_full && (InReg != 5'd0);

  assign WriteRegister = w_empty ? 5'd0  : r_reg[r_head];
  assign WriteData     = w_empty ? 32'd0 : r_data[r_head];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_tail <= r_tail + 1'b1;
      if (w_pop)
        r_head <= r_head + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && w_push) begin
      r_reg[r_tail]  <= InReg;
      r_data[r_tail] <= InData;
    end
  end

`ifdef WBQ_FORWARD_EN
  logic [AW-1:0] w_idx;

  // Walk oldest to youngest so the youngest match overrides.
  always_comb begin
    Fwd1Hit  = 1'b0;
    Fwd1Data = 32'd0;
    Fwd2Hit  = 1'b0;
    Fwd2Data = 32'd0;
    w_idx    = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + AW'(i);
      if ((AW+1)'(i) < r_count) begin
        if (ReadRegister1 != 5'd0 &&
            r_reg[w_idx] == ReadRegister1) begin
          Fwd1Hit  = 1'b1;
          Fwd1Data = r_data[w_idx];
        end
        if (ReadRegister2 != 5'd0 &&
            r_reg[w_idx] == ReadRegister2) begin
          Fwd2Hit  = 1'b1;
          Fwd2Data = r_data[w_idx];
        end
      end
    end
  end
`else
  logic w_unused;

  assign w_unused = ^{ReadRegister1, ReadRegister2};
  assign Fwd1Hit  = 1'b0;
  assign Fwd1Data = 32'd0;
  assign Fwd2Hit  = 1'b0;
  assign Fwd2Data = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed vector table then randomized
// traffic against a queue-based reference model.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef WBQ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [4:0]  InReg;
  logic [31:0] InData;
  logic        WbHold;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic        Fwd1Hit;
  logic [31:0] Fwd1Data;
  logic        Fwd2Hit;
  logic [31:0] Fwd2Data;
  logic [AW:0] Count;

  regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk(Clk), .Reset(Reset),
    .InValid(InValid), .InReady(InReady),
    .InReg(InReg), .InData(InData), .WbHold(WbHold),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .RegWrite(RegWrite),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .Fwd1Hit(Fwd1Hit), .Fwd1Data(Fwd1Data),
    .Fwd2Hit(Fwd2Hit), .Fwd2Data(Fwd2Data),
    .Count(Count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst, v;
    logic [4:0]  rg;
    logic [31:0] d;
    logic        hold;
    logic [4:0]  r1, r2;
    logic [2:0]  cnt;
    logic        rdy, we;
    logic [4:0]  wreg;
    logic [31:0] wd;
    logic        h1;
    logic [31:0] d1;
    logic        h2;
    logic [31:0] d2;
  } vec_t;

  typedef struct {
    logic [4:0]  rg;
    logic [31:0] d;
  } ent_t;

  vec_t tv[26];
  ent_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Model outputs
  logic [2:0]  m_cnt;
  logic        m_rdy, m_we, m_h1, m_h2;
  logic [4:0]  m_wreg;
  logic [31:0] m_wd, m_d1, m_d2;

  function automatic vec_t mk(
    logic rst, logic v, logic [4:0] rg, logic [31:0] d,
    logic hold, logic [4:0] r1, logic [4:0] r2,
    logic [2:0] cnt, logic rdy, logic we,
    logic [4:0] wreg, logic [31:0] wd,
    logic h1, logic [31:0] d1, logic h2, logic [31:0] d2);
    vec_t t;
    t.rst = rst; t.v = v; t.rg = rg; t.d = d;
    t.hold = hold; t.r1 = r1; t.r2 = r2;
    t.cnt = cnt; t.rdy = rdy; t.we = we;
    t.wreg = wreg; t.wd = wd;
    t.h1 = h1 & FWD; t.d1 = FWD ? d1 : 32'd0;
    t.h2 = h2 & FWD; t.d2 = FWD ? d2 : 32'd0;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic v, logic [4:0] rg,
                       logic [31:0] d, logic hold,
                       logic [4:0] r1, logic [4:0] r2);
    Reset = rst; InValid = v; InReg = rg; InData = d;
    WbHold = hold; ReadRegister1 = r1; ReadRegister2 = r2;
  endtask

  // Expected outputs straight from the queue contents.
  task automatic model_eval();
    m_cnt  = 3'(q.size());
    m_rdy  = q.size() < DEPTH;
    m_we   = !Reset && q.size() != 0 && !WbHold;
    m_wreg = q.size() != 0 ? q[0].rg : 5'd0;
    m_wd   = q.size() != 0 ? q[0].d : 32'd0;
    m_h1 = 1'b0; m_d1 = 32'd0; m_h2 = 1'b0; m_d2 = 32'd0;
    if (FWD) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!m_h1 && ReadRegister1 != 0 && q[i].rg == ReadRegister1) begin
          m_h1 = 1'b1; m_d1 = q[i].d;
        end
        if (!m_h2 && ReadRegister2 != 0 && q[i].rg == ReadRegister2) begin
          m_h2 = 1'b1; m_d2 = q[i].d;
        end
      end
    end
  endtask

  // Advance one clock and apply the same transition to the model.
  task automatic step();
    bit pop, push;
    model_eval();
    pop  = m_we;
    push = InValid && q.size() < DEPTH && InReg != 0;
    @(posedge Clk);
    if (Reset) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{InReg, InData});
    end
    #1;
  endtask

  task automatic check_model(string tag);
    model_eval();
    chk({tag, " Count"}, 32'(Count), 32'(m_cnt));
    chk({tag, " InReady"}, 32'(InReady), 32'(m_rdy));
    chk({tag, " RegWrite"}, 32'(RegWrite), 32'(m_we));
    chk({tag, " WriteRegister"}, 32'(WriteRegister), 32'(m_wreg));
    chk({tag, " WriteData"}, WriteData, m_wd);
    chk({tag, " Fwd1Hit"}, 32'(Fwd1Hit), 32'(m_h1));
    chk({tag, " Fwd1Data"}, Fwd1Data, m_d1);
    chk({tag, " Fwd2Hit"}, 32'(Fwd2Hit), 32'(m_h2));
    chk({tag, " Fwd2Data"}, Fwd2Data, m_d2);
  endtask

  initial begin
    // rst v rg d hold r1 r2 | cnt rdy we wreg wd h1 d1 h2 d2
    tv[0]  = mk(0,0,0,0,0,0,0, 0,1,0,0,0, 0,0,0,0);
    tv[1]  = mk(0,1,5,32'hAAAA0005,1,5,0, 0,1,0,0,0, 0,0,0,0);
    tv[2]  = mk(0,1,5,32'hBBBB0005,1,5,0, 1,1,0,5,32'hAAAA0005,
                1,32'hAAAA0005,0,0);
    tv[3]  = mk(0,0,0,0,1,5,0, 2,1,0,5,32'hAAAA0005,
                1,32'hBBBB0005,0,0);
    tv[4]  = mk(0,0,0,0,0,5,0, 2,1,1,5,32'hAAAA0005,
                1,32'hBBBB0005,0,0);
    tv[5]  = mk(0,0,0,0,0,5,0, 1,1,1,5,32'hBBBB0005,
                1,32'hBBBB0005,0,0);
    tv[6]  = mk(0,0,0,0,0,5,0, 0,1,0,0,0, 0,0,0,0);
    tv[7]  = mk(0,1,1,32'h11,1,0,0, 0,1,0,0,0, 0,0,0,0);
    tv[8]  = mk(0,1,2,32'h22,1,0,0, 1,1,0,1,32'h11, 0,0,0,0);
    tv[9]  = mk(0,1,3,32'h33,1,0,0, 2,1,0,1,32'h11, 0,0,0,0);
    tv[10] = mk(0,1,4,32'h44,1,0,3, 3,1,0,1,32'h11, 0,0,1,32'h33);
    tv[11] = mk(0,1,9,32'h99,1,0,0, 4,0,0,1,32'h11, 0,0,0,0);
    tv[12] = mk(0,1,9,32'h99,0,0,0, 4,0,1,1,32'h11, 0,0,0,0);
    tv[13] = mk(0,0,0,0,0,0,0, 3,1,1,2,32'h22, 0,0,0,0);
    tv[14] = mk(0,0,0,0,0,0,3, 2,1,1,3,32'h33, 0,0,1,32'h33);
    tv[15] = mk(0,0,0,0,0,0,3, 1,1,1,4,32'h44, 0,0,0,0);
    tv[16] = mk(0,0,0,0,0,0,0, 0,1,0,0,0, 0,0,0,0);
    tv[17] = mk(0,1,0,32'hDEADBEEF,0,0,0, 0,1,0,0,0, 0,0,0,0);
    tv[18] = mk(0,0,0,0,0,0,0, 0,1,0,0,0, 0,0,0,0);
    tv[19] = mk(0,1,10,32'hA,1,0,0, 0,1,0,0,0, 0,0,0,0);
    tv[20] = mk(0,1,11,32'hB,1,0,0, 1,1,0,10,32'hA, 0,0,0,0);
    tv[21] = mk(0,1,12,32'hC,1,0,0, 2,1,0,10,32'hA, 0,0,0,0);
    tv[22] = mk(1,0,0,0,0,0,0, 3,1,0,10,32'hA, 0,0,0,0);
    tv[23] = mk(0,1,7,32'h7,0,0,0, 0,1,0,0,0, 0,0,0,0);
    tv[24] = mk(0,0,0,0,0,0,0, 1,1,1,7,32'h7, 0,0,0,0);
    tv[25] = mk(0,0,0,0,0,0,0, 0,1,0,0,0, 0,0,0,0);

    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge Clk);
    #1;
    q.delete();

    for (int i = 0; i < 26; i++) begin
      drive(tv[i].rst, tv[i].v, tv[i].rg, tv[i].d,
            tv[i].hold, tv[i].r1, tv[i].r2);
      #2;
      chk($sformatf("v%0d Count", i), 32'(Count), 32'(tv[i].cnt));
      chk($sformatf("v%0d InReady", i), 32'(InReady), 32'(tv[i].rdy));
      chk($sformatf("v%0d RegWrite", i), 32'(RegWrite), 32'(tv[i].we));
      chk($sformatf("v%0d WriteRegister", i),
          32'(WriteRegister), 32'(tv[i].wreg));
      chk($sformatf("v%0d WriteData", i), WriteData, tv[i].wd);
      chk($sformatf("v%0d Fwd1Hit", i), 32'(Fwd1Hit), 32'(tv[i].h1));
      chk($sformatf("v%0d Fwd1Data", i), Fwd1Data, tv[i].d1);
      chk($sformatf("v%0d Fwd2Hit", i), 32'(Fwd2Hit), 32'(tv[i].h2));
      chk($sformatf("v%0d Fwd2Data", i), Fwd2Data, tv[i].d2);
      step();
    end

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 59) == 0,
            $urandom_range(0, 9) < 6,
            5'($urandom_range(0, 7)),
            $urandom,
            $urandom_range(0, 9) < 3,
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
      #2;
      check_model($sformatf("r%0d", i));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
